// File: rtl/cadence_gen.sv
// Programmable pedal-cadence square-wave generator with double-buffered period codes.
// Optional reed-switch bounce emulation is compiled in when CADENCE_BOUNCE_EN is defined.
module cadence_gen #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] per_in,
  input  logic       load,
  input  logic       en,
  output logic       cadence,
  output logic       rise_strb,
  output logic       active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int SHIFT = FAST_SIM ? 7 : 16;

`ifdef CADENCE_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;
`else
  localparam bit BOUNCE_ON = 1'b0;
`endif

  state_e      state_q;
  logic [7:0]  shadow_q;
  logic [7:0]  act_per_q;
  logic [23:0] cnt_q;
  logic        cadence_q;
  logic        rise_q;
  logic        active_q;

  logic [23:0] full_p;
  logic [23:0] half_p;
  logic [23:0] high_last;
  logic [23:0] low_last;
  logic [23:0] cnt_inc;
  logic [7:0]  eff_per;
  logic        eff_valid;

  // Inversion applied over the first twelve counts of a phase: 0-3 nominal, 4-7 flipped, 8-11 nominal.
  function automatic logic bounce(input logic [23:0] c);
    return BOUNCE_ON && (c < 24'd12) && c[2];
  endfunction

  always_comb begin
    full_p    = {16'd0, act_per_q} << SHIFT;
    half_p    = full_p >> 1;
    high_last = half_p - 24'd1;
    low_last  = full_p - half_p - 24'd1;
    cnt_inc   = cnt_q + 24'd1;
    // A load in the same cycle as a period boundary wins over the stored shadow.
    eff_per   = load ? per_in : shadow_q;
    eff_valid = (eff_per != 8'h00) && (eff_per <= 8'hE3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= 8'hE4;
      act_per_q <= 8'hE4;
      cnt_q     <= 24'd0;
      cadence_q <= 1'b0;
      rise_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (load) begin
        shadow_q <= per_in;
      end
      case (state_q)
        IDLE: begin
          cnt_q     <= 24'd0;
          cadence_q <= 1'b0;
          active_q  <= 1'b0;
          if (en && eff_valid) begin
            act_per_q <= eff_per;
            state_q   <= HIGH;
            cadence_q <= 1'b1;
            rise_q    <= 1'b1;
            active_q  <= 1'b1;
          end
        end
        HIGH: begin
          active_q <= 1'b1;
          if (cnt_q == high_last) begin
            cnt_q     <= 24'd0;
            state_q   <= LOW;
            cadence_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_inc;
            cadence_q <= ~bounce(cnt_inc);
          end
        end
        LOW: begin
          if (cnt_q == low_last) begin
            cnt_q <= 24'd0;
            // Period boundary: either start the next period or fall back to idle.
            if (en && eff_valid) begin
              act_per_q <= eff_per;
              state_q   <= HIGH;
              cadence_q <= 1'b1;
              rise_q    <= 1'b1;
              active_q  <= 1'b1;
            end else begin
              state_q   <= IDLE;
              cadence_q <= 1'b0;
              active_q  <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_inc;
            cadence_q <= bounce(cnt_inc);
            active_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= 24'd0;
          cadence_q <= 1'b0;
          active_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cadence   = cadence_q;
  assign rise_strb = rise_q;
  assign active    = active_q;

endmodule

// File: tb/tb_cadence_gen.sv
// Directed bench for cadence_gen (FAST_SIM=1): per-cycle vector table plus phase-level
// sequences for the multi-cycle corner cases.
module tb_cadence_gen;

  logic       clk;
  logic       rst;
  logic [7:0] per_in;
  logic       load;
  logic       en;
  logic       cadence;
  logic       rise_strb;
  logic       active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic [7:0] per;
    logic       exp_c;
    logic       exp_r;
    logic       exp_a;
  } vec_t;

  vec_t vecs[12];

`ifdef CADENCE_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;
`else
  localparam bit BOUNCE_ON = 1'b0;
`endif

  cadence_gen #(.FAST_SIM(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .per_in    (per_in),
    .load      (load),
    .en        (en),
    .cadence   (cadence),
    .rise_strb (rise_strb),
    .active    (active)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic exp_bounce(input int c);
    return BOUNCE_ON && (c < 12) && c[2];
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_phase(input logic lvl, input int n, input int c0,
                              input logic rise_first, input string name);
    int   bad;
    int   first_i;
    logic got_c, got_r, got_a, want_c, want_r;
    bad = 0;
    first_i = 0;
    got_c = 0; got_r = 0; got_a = 0; want_c = 0; want_r = 0;
    for (int i = 0; i < n; i++) begin
      logic ec, er;
      step();
      ec = lvl ^ exp_bounce(c0 + i);
      er = rise_first && (i == 0);
      if (cadence !== ec || rise_strb !== er || active !== 1'b1) begin
        if (bad == 0) begin
          first_i = i; got_c = cadence; got_r = rise_strb; got_a = active;
          want_c = ec; want_r = er;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d: cadence=%b rise=%b active=%b, required cadence=%b rise=%b active=1",
               name, bad, first_i, got_c, got_r, got_a, want_c, want_r);
    end
  endtask

  task automatic expect_idle(input int n, input string name);
    int   bad;
    int   first_i;
    logic got_c, got_r, got_a;
    bad = 0; first_i = 0; got_c = 0; got_r = 0; got_a = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (cadence !== 1'b0 || rise_strb !== 1'b0 || active !== 1'b0) begin
        if (bad == 0) begin
          first_i = i; got_c = cadence; got_r = rise_strb; got_a = active;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bad cycles, first at cycle %0d: cadence=%b rise=%b active=%b, required 0 0 0",
               name, bad, first_i, got_c, got_r, got_a);
    end
  endtask

  initial begin
    // Vector table: inputs applied before an edge, outputs compared just after it.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}; // shadow 0xE4: stay idle
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'hE4, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0}; // shadow only
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1}; // start from shadow 0x10
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}; // shadow back to 0xE4
    vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1}; // load at IDLE exit
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; load = 1'b0; en = 1'b0; per_in = 8'h00;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    expect_idle(100, "reset_idle");

    // Per-cycle table
    for (int v = 0; v < 12; v++) begin
      rst = vecs[v].rst; load = vecs[v].load; en = vecs[v].en; per_in = vecs[v].per;
      step();
      checks++;
      if (cadence !== vecs[v].exp_c || rise_strb !== vecs[v].exp_r || active !== vecs[v].exp_a) begin
        errors++;
        $display("FAIL vec[%0d]: cadence=%b rise=%b active=%b, required %b %b %b",
                 v, cadence, rise_strb, active, vecs[v].exp_c, vecs[v].exp_r, vecs[v].exp_a);
      end
    end

    // Enable dropped at HIGH cnt=1 of code 0x01 (H=64, P=128): period completes, then idle
    rst = 1'b0; load = 1'b0; en = 1'b0;
    expect_phase(1'b1, 62, 2, 1'b0, "endrop_high");
    expect_phase(1'b0, 64, 0, 1'b0, "endrop_low");
    expect_idle(10, "endrop_idle");

    // Basic waveform: code 0x10 loaded together with en
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1; load = 1'b1; per_in = 8'h10;
    expect_phase(1'b1, 1, 0, 1'b1, "basic_rise");
    load = 1'b0;
    expect_phase(1'b1, 1023, 1, 1'b0, "basic_high");
    expect_phase(1'b0, 1024, 0, 1'b0, "basic_low");

    // Period change mid-HIGH: current period unchanged, next one is 0x08
    expect_phase(1'b1, 100, 0, 1'b1, "chg_high_a");
    load = 1'b1; per_in = 8'h08;
    expect_phase(1'b1, 1, 100, 1'b0, "chg_load");
    load = 1'b0;
    expect_phase(1'b1, 923, 101, 1'b0, "chg_high_b");
    expect_phase(1'b0, 1024, 0, 1'b0, "chg_low");
    expect_phase(1'b1, 512, 0, 1'b1, "new_high");

    // Invalid code loaded mid-LOW: period completes, then idle even with en=1
    expect_phase(1'b0, 200, 0, 1'b0, "inv_low_a");
    load = 1'b1; per_in = 8'h00;
    expect_phase(1'b0, 1, 200, 1'b0, "inv_load");
    load = 1'b0;
    expect_phase(1'b0, 311, 201, 1'b0, "inv_low_b");
    expect_idle(20, "inv_idle");

    // Reset mid-LOW at cnt=500
    load = 1'b1; per_in = 8'h10;
    expect_phase(1'b1, 1, 0, 1'b1, "rst_run_rise");
    load = 1'b0;
    expect_phase(1'b1, 1023, 1, 1'b0, "rst_run_high");
    expect_phase(1'b0, 501, 0, 1'b0, "rst_run_low");
    rst = 1'b1;
    expect_idle(1, "rst_midlow");
    rst = 1'b0;
    expect_idle(10, "rst_shadow_e4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
